chunked_borrow_subtractor: RTL and testbench
============================================

CHUNKED_BORROW_SUBTRACTOR -- requirements
Module: chunked_borrow_subtractor

Interface
REQ-001 SHALL have parameter D_WIDTH, default 64: operand and result width in bits.
REQ-002 SHALL have parameter C_WIDTH, default 16: bits processed per cycle; D_WIDTH % C_WIDTH == 0 and C_WIDTH >= 1 are legal; N = D_WIDTH/C_WIDTH.
REQ-003 SHALL have port clk_i, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst_i, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port a_i, input, D_WIDTH: minuend, unsigned.
REQ-006 SHALL have port b_i, input, D_WIDTH: subtrahend, unsigned.
REQ-007 SHALL have port c_i, input, 1: borrow-in.
REQ-008 SHALL have port in_valid_i, input, 1: operands valid.
REQ-009 SHALL have port in_ready_o, output, 1: block can accept operands.
REQ-010 SHALL have port s_o, output, D_WIDTH: difference.
REQ-011 SHALL have port c_o, output, 1: borrow-out.
REQ-012 SHALL have port out_valid_o, output, 1: result valid.
REQ-013 SHALL have port out_ready_i, input, 1: consumer accepts result.

Function
REQ-014 SHALL compute s_o = (a_i - b_i - c_i) mod 2^D_WIDTH and c_o = 1 iff a_i < b_i + c_i (unsigned), using the operands and c_i sampled at input handshake.
REQ-015 SHALL implement FSM states IDLE, CALC, DONE.
REQ-016 SHALL assert in_ready_o only in IDLE; input handshake = in_valid_i & in_ready_o at a rising edge.
REQ-017 On input handshake, SHALL register a_i, b_i, c_i, clear chunk counter to 0 and go to CALC.
REQ-018 In CALC, each cycle SHALL subtract chunk k (bits k*C_WIDTH+C_WIDTH-1 .. k*C_WIDTH) with the running borrow, write that chunk of s_o, update the borrow and increment k.
REQ-019 SHALL leave CALC for DONE after processing chunk N-1; out_valid_o rises exactly N cycles after the input handshake edge.
REQ-020 In DONE, SHALL hold out_valid_o=1 with s_o and c_o stable until out_ready_i=1 at a rising edge, then go to IDLE with out_valid_o=0.
REQ-021 SHALL ignore in_valid_i and input changes outside IDLE; registered operands never change in CALC or DONE.
REQ-022 When N=1, SHALL spend exactly one cycle in CALC.
REQ-023 s_o and c_o SHALL be don't-care while out_valid_o=0, but SHALL NOT contain X after reset.

Reset
REQ-024 While rst_i=1, SHALL force state IDLE, counter 0, s_o=0, c_o=0, out_valid_o=0, in_ready_o=1 (in_ready_o after deassertion).
REQ-025 Reset asserted in CALC or DONE SHALL abandon the operation with no result emitted; the first handshake after deassertion starts a fresh operation.

Configuration
REQ-026 With macro CHUNKED_BORROW_SUBTRACTOR_ZERO_FLAG_EN defined, SHALL add output z_o (1 bit), valid with out_valid_o, =1 iff s_o==0, reset value 0, accumulated per chunk during CALC.
REQ-027 Without CHUNKED_BORROW_SUBTRACTOR_ZERO_FLAG_EN, port z_o and its logic SHALL NOT exist; all other behaviour is identical.

Verification (D_WIDTH=64, C_WIDTH=16, out_ready_i=1 unless stated)
REQ-028 a=5, b=3, c=0 -> s_o=2, c_o=0, out_valid_o high 4 cycles after handshake, one cycle wide.
REQ-029 a=0, b=1, c=0 -> s_o=0xFFFF_FFFF_FFFF_FFFF, c_o=1; a=0, b=0, c=1 -> same result.
REQ-030 Borrow across chunks: a=0x0000_0000_0001_0000, b=1, c=0 -> s_o=0x0000_0000_0000_FFFF, c_o=0; a=0x1_0000_0000_0000, b=1 -> s_o=0x0000_FFFF_FFFF_FFFF.
REQ-031 Backpressure: out_ready_i=0 for 10 cycles in DONE -> s_o/c_o/out_valid_o stable, in_ready_o=0; input changes ignored; on out_ready_i=1 -> IDLE next cycle.
REQ-032 Reset in 2nd CALC cycle -> out_valid_o=0, in_ready_o=1 after release, no stale result; next op a=7, b=7 -> s_o=0, c_o=0 (z_o=1 with ZERO_FLAG_EN).

Source files
------------

// File: rtl/chunked_borrow_subtractor.sv
// rtl/chunked_borrow_subtractor.sv - multi-cycle subtractor, one C_WIDTH chunk per cycle with rippled borrow
// Optional zero flag output z_o: define CHUNKED_BORROW_SUBTRACTOR_ZERO_FLAG_EN.
module chunked_borrow_subtractor #(
  parameter int D_WIDTH = 64,
  parameter int C_WIDTH = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [D_WIDTH-1:0] a_i,
  input  logic [D_WIDTH-1:0] b_i,
  input  logic               c_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [D_WIDTH-1:0] s_o,
  output logic               c_o,
`ifdef CHUNKED_BORROW_SUBTRACTOR_ZERO_FLAG_EN
  output logic               z_o,
`endif
  output logic               out_valid_o,
  input  logic               out_ready_i
);

  localparam int N     = D_WIDTH / C_WIDTH;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state_q, state_d;
  logic [D_WIDTH-1:0] a_q, a_d;
  logic [D_WIDTH-1:0] b_q, b_d;
  logic [D_WIDTH-1:0] s_q, s_d;
  logic               borrow_q, borrow_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [C_WIDTH:0]   chunk_diff;
`ifdef CHUNKED_BORROW_SUBTRACTOR_ZERO_FLAG_EN
  logic               z_q, z_d;
`endif

  // Current chunk difference; the extra top bit goes high when the chunk result is negative (borrow out).
  always_comb begin
    chunk_diff = {1'b0, a_q[k_q*C_WIDTH +: C_WIDTH]}
               - {1'b0, b_q[k_q*C_WIDTH +: C_WIDTH]}
               - {{C_WIDTH{1'b0}}, borrow_q};
  end

  // Next-state and datapath updates for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    s_d      = s_q;
    borrow_d = borrow_q;
    k_d      = k_q;
`ifdef CHUNKED_BORROW_SUBTRACTOR_ZERO_FLAG_EN
    z_d      = z_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          a_d      = a_i;
          b_d      = b_i;
          borrow_d = c_i;
          k_d      = '0;
`ifdef CHUNKED_BORROW_SUBTRACTOR_ZERO_FLAG_EN
          z_d      = 1'b1;
`endif
          state_d  = CALC;
        end
      end
      CALC: begin
        s_d[k_q*C_WIDTH +: C_WIDTH] = chunk_diff[C_WIDTH-1:0];
        borrow_d = chunk_diff[C_WIDTH];
`ifdef CHUNKED_BORROW_SUBTRACTOR_ZERO_FLAG_EN
        z_d      = z_q & (chunk_diff[C_WIDTH-1:0] == '0);
`endif
        if (k_q == LAST_K) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d     = k_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      borrow_q <= 1'b0;
      k_q      <= '0;
`ifdef CHUNKED_BORROW_SUBTRACTOR_ZERO_FLAG_EN
      z_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      s_q      <= s_d;
      borrow_q <= borrow_d;
      k_q      <= k_d;
`ifdef CHUNKED_BORROW_SUBTRACTOR_ZERO_FLAG_EN
      z_q      <= z_d;
`endif
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign s_o         = s_q;
  assign c_o         = borrow_q;
`ifdef CHUNKED_BORROW_SUBTRACTOR_ZERO_FLAG_EN
  assign z_o         = z_q;
`endif

endmodule

// File: tb/tb_chunked_borrow_subtractor.sv
// tb/tb_chunked_borrow_subtractor.sv - directed self-checking bench for chunked_borrow_subtractor
module tb_chunked_borrow_subtractor;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [63:0] a_i, b_i, s_o;
  logic        c_i, in_valid_i, in_ready_o, c_o, out_valid_o, out_ready_i;
`ifdef CHUNKED_BORROW_SUBTRACTOR_ZERO_FLAG_EN
  logic        z_o;
`endif

  int n_pass  = 0;
  int n_total = 0;

  chunked_borrow_subtractor #(.D_WIDTH(64), .C_WIDTH(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .c_i         (c_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .s_o         (s_o),
    .c_o         (c_o),
`ifdef CHUNKED_BORROW_SUBTRACTOR_ZERO_FLAG_EN
    .z_o         (z_o),
`endif
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Handshake one operation at a falling edge; returns latency in rising edges once out_valid_o is seen.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b, input logic c, output int lat);
    check("in_ready_before_op", {63'd0, in_ready_o}, 64'd1);
    a_i = a; b_i = b; c_i = c; in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    a_i = 64'hDEAD_BEEF_DEAD_BEEF; b_i = 64'h1234_5678_9ABC_DEF0; c_i = 1'b1;
    lat = 0;
    while (!out_valid_o && lat < 20) begin
      @(negedge clk_i);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic c, input logic [63:0] exp_s, input logic exp_c);
    int lat;
    start_op(a, b, c, lat);
    check({tag, "_latency"}, 64'(lat), 64'd4);
    check({tag, "_s"}, s_o, exp_s);
    check({tag, "_c"}, {63'd0, c_o}, {63'd0, exp_c});
`ifdef CHUNKED_BORROW_SUBTRACTOR_ZERO_FLAG_EN
    check({tag, "_z"}, {63'd0, z_o}, {63'd0, exp_s == 64'd0});
`endif
    @(negedge clk_i);
    check({tag, "_valid_one_cycle"}, {63'd0, out_valid_o}, 64'd0);
  endtask

  initial begin
    int lat;
    logic [63:0] held_s;
    rst_i = 1'b1; a_i = '0; b_i = '0; c_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rst_out_valid", {63'd0, out_valid_o}, 64'd0);
    check("rst_s", s_o, 64'd0);
    check("rst_c", {63'd0, c_o}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_in_ready", {63'd0, in_ready_o}, 64'd1);

    run_op("simple",     64'd5, 64'd3, 1'b0, 64'd2, 1'b0);
    run_op("underflow_b", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op("underflow_c", 64'd0, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    run_op("borrow_1chunk", 64'h0000_0000_0001_0000, 64'd1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0);
    run_op("borrow_3chunk", 64'h0001_0000_0000_0000, 64'd1, 1'b0, 64'h0000_FFFF_FFFF_FFFF, 1'b0);
    run_op("max_minus_c", 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    run_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 64'h0246_8ACF_1357_9BCF, 1'b0);

    // Backpressure: hold DONE for 10 cycles while inputs wiggle.
    out_ready_i = 1'b0;
    start_op(64'd100, 64'd1, 1'b0, lat);
    check("bp_latency", 64'(lat), 64'd4);
    check("bp_s", s_o, 64'd99);
    held_s = s_o;
    for (int i = 0; i < 10; i++) begin
      a_i = 64'(i * 77); b_i = 64'(i); in_valid_i = 1'b1;
      @(negedge clk_i);
      if (s_o !== held_s || c_o !== 1'b0 || out_valid_o !== 1'b1 || in_ready_o !== 1'b0)
        check("bp_hold", {s_o[60:0], c_o, out_valid_o, in_ready_o}, {held_s[60:0], 3'b010});
      else
        check("bp_hold", 64'd1, 64'd1 & {63'd0, out_valid_o});
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    check("bp_release_valid", {63'd0, out_valid_o}, 64'd0);
    check("bp_release_ready", {63'd0, in_ready_o}, 64'd1);

    // Reset during the second CALC cycle abandons the operation.
    a_i = 64'd9; b_i = 64'd4; c_i = 1'b0; in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    check("midrst_valid", {63'd0, out_valid_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_ready", {63'd0, in_ready_o}, 64'd1);
    repeat (5) @(negedge clk_i);
    check("midrst_no_stale", {63'd0, out_valid_o}, 64'd0);
    run_op("after_rst", 64'd7, 64'd7, 1'b0, 64'd0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
